// File: rtl/arb2_rr_ctrl_if.sv
// Handshake bundle between the requesting clients and the two-way round-robin arbiter.
// The master side drives requests and enable. The slave side, the arbiter, returns grants and status.
interface arb2_rr_ctrl_if;
    logic enable;
    logic req_0;
    logic req_1;
    logic gnt_0;
    logic gnt_1;
    logic busy;
    logic timeout;

    modport master (
        output enable,
        output req_0,
        output req_1,
        input  gnt_0,
        input  gnt_1,
        input  busy,
        input  timeout
    );

    modport slave (
        input  enable,
        input  req_0,
        input  req_1,
        output gnt_0,
        output gnt_1,
        output busy,
        output timeout
    );
endinterface

// File: rtl/arb2_rr_ctrl.sv
// Two-client round-robin arbiter with registered grants and a mandatory IDLE turnaround cycle.
// A hold watchdog reclaims the resource after MAX_HOLD cycles.
module arb2_rr_ctrl #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                clock,
    input  logic                reset,
    arb2_rr_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam bit               WDOG_EN    = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_0_q, gnt_0_d;
    logic             gnt_1_q, gnt_1_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic             owner_req;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        owner_req = (state_q == GNT0) ? bus.req_0 : bus.req_1;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    // On a tie, the client that did not own the bus most recently wins.
                    if (bus.req_0 && (!bus.req_1 || last_q)) begin
                        state_d = GNT0;
                        last_d  = 1'b0;
                        cnt_d   = ONE_C;
                    end else if (bus.req_1) begin
                        state_d = GNT1;
                        last_d  = 1'b1;
                        cnt_d   = ONE_C;
                    end
                end
            end
            GNT0, GNT1: begin
                // A voluntary release takes precedence over the watchdog firing.
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (WDOG_EN && (cnt_q == MAX_HOLD_C)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_0_d = (state_d == GNT0);
        gnt_1_d = (state_d == GNT1);
        busy_d  = gnt_0_d | gnt_1_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            gnt_0_q   <= 1'b0;
            gnt_1_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt_0_q   <= gnt_0_d;
            gnt_1_q   <= gnt_1_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt_0   = gnt_0_q;
    assign bus.gnt_1   = gnt_1_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: doc/arb2_rr_ctrl.md
# arb2_rr_ctrl

Two-requester round-robin arbiter controller granting exclusive ownership of a shared resource (address/data bus) to `req_0` / `req_1` clients. Registered grants, mandatory one-cycle bus turnaround between owners, and a hold watchdog that forcibly reclaims the resource from a requester that never releases it. Sits between the requesting client blocks and the shared bus mux; `gnt_0`/`gnt_1` directly drive the mux select and client enables.

## Interface
- `MAX_HOLD`, 16, max consecutive grant cycles per ownership; 0 disables the watchdog
- `CNT_W`, 5, hold-counter width; must satisfy MAX_HOLD < 2**CNT_W

- `clock`  in  1  single clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  1 = new grants may be issued; 0 = no new grants, current grant completes normally
- `req_0`  in  1  request from client 0, level; held while ownership wanted
- `req_1`  in  1  request from client 1, level
- `gnt_0`  out  1  registered grant to client 0
- `gnt_1`  out  1  registered grant to client 1
- `busy`  out  1  registered, equals gnt_0 | gnt_1
- `timeout`  out  1  one-cycle pulse: a grant was reclaimed by the watchdog

## Operation
- States: IDLE, GNT0, GNT1. gnt_0 = (state==GNT0), gnt_1 = (state==GNT1); never both high.
- Internal `last` (1 bit): owner of most recent grant; reset value 1 so client 0 wins the first tie.
- IDLE, enable=1: only req_0 -> GNT0; only req_1 -> GNT1; both -> grant client != last; none -> stay.
- IDLE, enable=0: stay regardless of requests.
- On entry to GNTx: last <= x, hold counter <= 1.
- GNTx: req_x=0 -> IDLE (normal release). Else if MAX_HOLD!=0 and counter==MAX_HOLD -> IDLE, timeout <= 1 (forced release). Else stay, counter += 1.
- Release precedence: req_x=0 in the same cycle the counter reaches MAX_HOLD is a normal release; no timeout.
- No direct GNT0<->GNT1 transition: every ownership change passes through at least one IDLE cycle (turnaround).
- After forced release the timed-out client has lowest priority (last = x); if it alone still requests, it is re-granted after the IDLE cycle.
- enable deassertion during GNTx has no effect on that grant.
- Counter saturation is impossible by the CNT_W constraint; with MAX_HOLD=0 counter is held at 1 (no wrap, no timeout).

## Timing
- Reset (async assert, synchronous deassert by caller): state=IDLE, gnt_0=0, gnt_1=0, busy=0, timeout=0, last=1, counter=0. Reset mid-grant drops grant immediately (asynchronously).
- Request-to-grant latency: req sampled high at edge N in IDLE -> gnt high after edge N (visible cycle N+1). One cycle minimum.
- Release latency: req_x sampled low at edge N -> gnt_x low after edge N; other client earliest grant after edge N+1.
- Max grant duration: exactly MAX_HOLD cycles of gnt_x high, then gnt_x low and timeout high for one cycle (the IDLE cycle).
- timeout only ever high in IDLE, for exactly one cycle per forced release.
- busy tracks gnt_0|gnt_1 with identical timing.

## Test plan
- Reset: assert reset low mid-GNT1 -> gnt_1, busy drop at once; after release, req_0=req_1=1 simultaneously -> gnt_0 one cycle later (last=1 at reset).
- Alternation: req_0=req_1=1 held, MAX_HOLD=0, each client drops its req after 3 grant cycles and reasserts next cycle -> pattern gnt_0 x3, IDLE x1, gnt_1 x3, IDLE x1, repeating; gnt_0&gnt_1 never 1.
- Watchdog: MAX_HOLD=16, req_0 held high forever, req_1=0 -> gnt_0 high 16 cycles, one IDLE cycle with timeout=1, gnt_0 high again for 16 cycles; repeats.
- Fairness after timeout: req_0 held, req_1 asserted on cycle 5 of gnt_0 -> gnt_0 forced off after 16 cycles, timeout pulse, then gnt_1 granted.
- Release precedence: req_0 dropped on the same edge the counter hits MAX_HOLD -> gnt_0 falls, timeout stays 0.
- Enable: enable=0 with req_1=1 in IDLE -> no grant for 10 cycles; enable=1 -> gnt_1 next cycle; enable=0 during GNT1 -> grant continues until req_1 drops.
